// File: rtl/mvu_vec_replay.sv
// rtl/mvu_vec_replay.sv - capture one folded activation vector and replay it REP times to the MVU
//
// Purpose:
//   Sits directly upstream of the MVU compute core. Each vector of LEN words
//   is streamed straight through on its first pass and is written into a
//   local buffer at the same time. Passes 2..REP are then read back from that
//   buffer. olast marks the last word of every pass and ofin marks the last
//   word of the final pass.
//
// Ports:
//   clk    in   1  clock
//   rst    in   1  asynchronous active-high reset
//   ivld   in   1  input word valid
//   irdy   out  1  input word ready (only ever high while filling)
//   idat   in   W  input word
//   ovld   out  1  output word valid
//   ordy   in   1  output ready from the MVU
//   odat   out  W  output word
//   olast  out  1  last word of the current pass
//   ofin   out  1  last word of the final pass of the vector
module mvu_vec_replay #(
  parameter int LEN = 4,
  parameter int REP = 3,
  parameter int W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ivld,
  output logic         irdy,
  input  logic [W-1:0] idat,
  output logic         ovld,
  input  logic         ordy,
  output logic [W-1:0] odat,
  output logic         olast,
  output logic         ofin
);

  generate
    if (LEN < 1 || REP < 1) begin : g_bad_param
      $error("mvu_vec_replay: LEN and REP must both be >= 1");
    end
  endgenerate

  localparam int PW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int RW = (REP > 1) ? $clog2(REP) : 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(LEN - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);

  typedef enum logic [0:0] {
    FILL   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [RW-1:0] rep;
  logic [RW-1:0] rep_nxt;

  logic [W-1:0]  mem [LEN];

  logic          adv;
  logic          load;
  logic          wr_en;
  logic          ptr_last;
  logic          rep_last;

  // The output register may take a new word whenever it is empty or the
  // MVU is taking the current one.
  assign adv      = !ovld || ordy;
  assign ptr_last = (ptr == PTR_LAST);
  assign rep_last = (rep == REP_LAST);

  // State, pointer and pass counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      ptr   <= '0;
      rep   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      rep   <= rep_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    rep_nxt   = rep;
    irdy      = 1'b0;
    load      = 1'b0;
    wr_en     = 1'b0;

    case (state)
      FILL: begin
        irdy  = adv;
        load  = adv && ivld;
        wr_en = load;
      end
      REPLAY: begin
        // The buffer always holds a complete vector here, so a source word
        // exists on every cycle the output register can advance.
        load = adv;
      end
      default: begin
        state_nxt = FILL;
      end
    endcase

    if (load) begin
      if (ptr_last) begin
        ptr_nxt = '0;
        if (rep_last) begin
          rep_nxt   = '0;
          state_nxt = FILL;
        end else begin
          rep_nxt   = rep + RW'(1);
          state_nxt = REPLAY;
        end
      end else begin
        ptr_nxt = ptr + PW'(1);
      end
    end
  end

  // Vector buffer. Slot ptr is rewritten in FILL only after the final
  // replay pass has already read it, so no read/write hazard exists.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr] <= idat;
    end
  end

  // Output register; doubles as the synchronous read register of the buffer.
  // rep is 0 throughout FILL, so ptr_last && rep_last reduces to
  // (ptr==LEN-1 && REP==1) there and gives the final-pass flag in REPLAY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovld  <= 1'b0;
      odat  <= '0;
      olast <= 1'b0;
      ofin  <= 1'b0;
    end else if (adv) begin
      if (load) begin
        ovld  <= 1'b1;
        odat  <= (state == FILL) ? idat : mem[ptr];
        olast <= ptr_last;
        ofin  <= ptr_last && rep_last;
      end else begin
        ovld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mvu_vec_replay.sv
// tb/tb_mvu_vec_replay.sv - scoreboard bench for mvu_vec_replay in three fold configurations
module tb_mvu_vec_replay;

  // Instance 0: LEN=4 REP=3, instance 1: LEN=2 REP=1, instance 2: LEN=1 REP=4.
  logic        clk;
  logic        rst;
  logic        ivld  [3];
  logic        irdy  [3];
  logic [31:0] idat  [3];
  logic        ovld  [3];
  logic        ordy  [3];
  logic [31:0] odat  [3];
  logic        olast [3];
  logic        ofin  [3];

  typedef struct {
    logic [31:0] dat;
    logic        last;
    logic        fin;
    int          idx;
  } exp_t;

  exp_t sb [3][$];

  int n_cmp;
  int n_mis;
  int cyc;

  mvu_vec_replay #(.LEN(4), .REP(3), .W(32)) u_dut0 (
    .clk(clk), .rst(rst), .ivld(ivld[0]), .irdy(irdy[0]), .idat(idat[0]),
    .ovld(ovld[0]), .ordy(ordy[0]), .odat(odat[0]), .olast(olast[0]), .ofin(ofin[0])
  );

  mvu_vec_replay #(.LEN(2), .REP(1), .W(32)) u_dut1 (
    .clk(clk), .rst(rst), .ivld(ivld[1]), .irdy(irdy[1]), .idat(idat[1]),
    .ovld(ovld[1]), .ordy(ordy[1]), .odat(odat[1]), .olast(olast[1]), .ofin(ofin[1])
  );

  mvu_vec_replay #(.LEN(1), .REP(4), .W(32)) u_dut2 (
    .clk(clk), .rst(rst), .ivld(ivld[2]), .irdy(irdy[2]), .idat(idat[2]),
    .ovld(ovld[2]), .ordy(ordy[2]), .odat(odat[2]), .olast(olast[2]), .ofin(ofin[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int len_of(input int d);
    case (d)
      0: return 4;
      1: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int rep_of(input int d);
    case (d)
      0: return 3;
      1: return 1;
      default: return 4;
    endcase
  endfunction

  // Expected output sequence of one vector: REP passes over LEN words.
  task automatic push_vec(input int d, input logic [31:0] v [4]);
    exp_t e;
    int   l = len_of(d);
    int   r = rep_of(d);
    for (int p = 0; p < r; p++) begin
      for (int i = 0; i < l; i++) begin
        e.dat  = v[i];
        e.last = (i == l - 1);
        e.fin  = (i == l - 1) && (p == r - 1);
        e.idx  = p * l + i;
        sb[d].push_back(e);
      end
    end
  endtask

  // Offer one word after gap idle cycles and hold it until accepted.
  task automatic send(input int d, input logic [31:0] w, input int gap);
    bit ok = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    ivld[d] = 1'b1;
    idat[d] = w;
    for (int b = 0; b < 500 && !ok; b++) begin
      @(negedge clk);
      ok = irdy[d];
      @(posedge clk);
      #1;
    end
    ivld[d] = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_mis++;
      $display("FAIL send_timeout dut%0d: word %h not accepted, required acceptance", d, w);
    end
  endtask

  // Consume n output handshakes, comparing each against the scoreboard head.
  // exp_idle >= 0 also checks the number of empty output cycles between the
  // first and last handshake; exp_idle == 0 additionally requires them to be
  // back-to-back.
  task automatic run_check(input int d, input int n, input bit rnd, input int exp_idle,
                           input string nm);
    int          got     = 0;
    int          idle    = 0;
    int          first   = -1;
    int          last_c  = 0;
    bit          stalled = 1'b0;
    logic [31:0] hold_d  = '0;
    logic        hold_l  = 1'b0;
    logic        exp_rdy;
    exp_t        e;
    int          l = len_of(d);
    int          r = rep_of(d);
    for (int b = 0; b < 2000 && got < n; b++) begin
      @(negedge clk);
      if (stalled) begin
        n_cmp++;
        if (ovld[d] !== 1'b1 || odat[d] !== hold_d || olast[d] !== hold_l) begin
          n_mis++;
          $display("FAIL %s_hold: ovld=%b odat=%h olast=%b, required 1 %h %b", nm,
                   ovld[d], odat[d], olast[d], hold_d, hold_l);
        end
      end
      stalled = ovld[d] && !ordy[d];
      hold_d  = odat[d];
      hold_l  = olast[d];
      if (ovld[d] && sb[d].size() > 0) begin
        e = sb[d][0];
        n_cmp++;
        if (odat[d] !== e.dat || olast[d] !== e.last || ofin[d] !== e.fin) begin
          n_mis++;
          $display("FAIL %s_data #%0d: odat=%h olast=%b ofin=%b, required %h %b %b", nm, got,
                   odat[d], olast[d], ofin[d], e.dat, e.last, e.fin);
        end
        // Input side is only open while the block is filling.
        exp_rdy = ordy[d] && ((e.idx < l - 1) || (e.idx == l * r - 1));
        n_cmp++;
        if (irdy[d] !== exp_rdy) begin
          n_mis++;
          $display("FAIL %s_irdy #%0d: irdy=%b, required %b", nm, got, irdy[d], exp_rdy);
        end
        if (ordy[d]) begin
          void'(sb[d].pop_front());
          got++;
          if (first < 0) first = cyc;
          last_c = cyc;
        end
      end else if (ovld[d]) begin
        n_cmp++;
        n_mis++;
        $display("FAIL %s_extra: odat=%h, required no output", nm, odat[d]);
      end else if (first >= 0) begin
        idle++;
      end
      @(posedge clk);
      #1;
      ordy[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    ordy[d] = 1'b1;
    n_cmp++;
    if (got != n) begin
      n_mis++;
      $display("FAIL %s_count: handshakes=%0d, required %0d", nm, got, n);
    end
    if (exp_idle >= 0) begin
      n_cmp++;
      if (idle != exp_idle) begin
        n_mis++;
        $display("FAIL %s_idle: empty cycles=%0d, required %0d", nm, idle, exp_idle);
      end
      if (exp_idle == 0) begin
        n_cmp++;
        if (last_c - first != n - 1) begin
          n_mis++;
          $display("FAIL %s_span: cycles=%0d, required %0d", nm, last_c - first, n - 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (ovld[d] !== 1'b0 || odat[d] !== 32'h0 || olast[d] !== 1'b0 || ofin[d] !== 1'b0
          || irdy[d] !== 1'b1) begin
        n_mis++;
        $display("FAIL reset dut%0d: ovld=%b odat=%h olast=%b ofin=%b irdy=%b, required 0 0 0 0 1",
                 d, ovld[d], odat[d], olast[d], ofin[d], irdy[d]);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] v [4];
    v = '{32'hA, 32'hB, 32'hC, 32'hD};
    push_vec(0, v);
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, v[i], 0);
      end
      run_check(0, 12, 1'b0, 0, "basic");
    join
  endtask

  task automatic test_back_to_back();
    logic [31:0] v1 [4];
    logic [31:0] v2 [4];
    v1 = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    v2 = '{32'hDEAD_0005, 32'hBEEF_0006, 32'hCAFE_0007, 32'hF00D_0008};
    push_vec(0, v1);
    push_vec(0, v2);
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, v1[i], 0);
        for (int i = 0; i < 4; i++) send(0, v2[i], 0);
      end
      run_check(0, 24, 1'b1, -1, "b2b");
    join
  endtask

  task automatic test_rep1();
    logic [31:0] v [4];
    for (int k = 0; k < 4; k++) begin
      v = '{32'(2 * k + 1), 32'(2 * k + 2), 32'h0, 32'h0};
      push_vec(1, v);
    end
    fork
      begin
        for (int i = 1; i <= 8; i++) send(1, 32'(i), 0);
      end
      run_check(1, 8, 1'b0, 0, "rep1");
    join
  endtask

  task automatic test_len1();
    logic [31:0] v [4];
    v = '{32'h55, 32'h0, 32'h0, 32'h0};
    push_vec(2, v);
    v = '{32'h66, 32'h0, 32'h0, 32'h0};
    push_vec(2, v);
    fork
      begin
        send(2, 32'h55, 0);
        send(2, 32'h66, 0);
      end
      run_check(2, 8, 1'b0, 0, "len1");
    join
  endtask

  task automatic test_reset_mid();
    logic [31:0] v [4];
    v = '{32'hA0, 32'hB0, 32'hC0, 32'hD0};
    push_vec(0, v);
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, v[i], 0);
      end
      run_check(0, 6, 1'b0, -1, "pre_rst");
    join
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ovld[0] !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_async: ovld=%b, required 0", ovld[0]);
    end
    sb[0].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (irdy[0] !== 1'b1 || ovld[0] !== 1'b0) begin
      n_mis++;
      $display("FAIL rst_release: irdy=%b ovld=%b, required 1 0", irdy[0], ovld[0]);
    end
    v = '{32'hE, 32'hF, 32'h10, 32'h11};
    push_vec(0, v);
    fork
      begin
        for (int i = 0; i < 4; i++) send(0, v[i], 0);
      end
      run_check(0, 12, 1'b0, 0, "post_rst");
    join
  endtask

  task automatic test_ivld_gap();
    logic [31:0] v [4];
    v = '{32'h0A0A, 32'h0B0B, 32'h0C0C, 32'h0D0D};
    push_vec(0, v);
    fork
      begin
        send(0, v[0], 0);
        send(0, v[1], 0);
        send(0, v[2], 5);
        send(0, v[3], 0);
      end
      run_check(0, 12, 1'b0, 5, "gap");
    join
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    cyc   = 0;
    rst   = 1'b1;
    for (int d = 0; d < 3; d++) begin
      ivld[d] = 1'b0;
      idat[d] = '0;
      ordy[d] = 1'b1;
    end
    test_reset();
    test_basic();
    test_back_to_back();
    test_rep1();
    test_len1();
    test_reset_mid();
    test_ivld_gap();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
